// File: rtl/mem_access_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_pkg
// Shared definitions for the load/store sequencer: access size encodings,
// sequencer state encoding and lane/alignment mask helpers.
// ---------------------------------------------------------------------------
package mem_access_pkg;

   localparam int BYTES_PER_WORD = 8;
   localparam int LANE_BITS      = 8;

   typedef enum logic [1:0] {
      SZ_BYTE  = 2'b00,
      SZ_HALF  = 2'b01,
      SZ_WORD  = 2'b10,
      SZ_DWORD = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      READ  = 2'b01,
      WRITE = 2'b10,
      RESP  = 2'b11
   } state_e;

   // Low address bits that must be zero for a naturally aligned access.
   function automatic logic [2:0] align_mask(input logic [1:0] size);
      logic [2:0] mask;
      case (size_e'(size))
         SZ_BYTE:  mask = 3'b000;
         SZ_HALF:  mask = 3'b001;
         SZ_WORD:  mask = 3'b011;
         default:  mask = 3'b111;
      endcase
      return mask;
   endfunction

   // Byte lanes touched by an access of this size starting at lane 0.
   function automatic logic [BYTES_PER_WORD-1:0] size_lane_mask(input logic [1:0] size);
      logic [BYTES_PER_WORD-1:0] mask;
      case (size_e'(size))
         SZ_BYTE:  mask = 8'h01;
         SZ_HALF:  mask = 8'h03;
         SZ_WORD:  mask = 8'h0F;
         default:  mask = 8'hFF;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/byte_lane_align.sv
// ---------------------------------------------------------------------------
// byte_lane_align
// Combinational byte-lane steering shared by the load and read-modify-write
// paths of mem_access_unit. Little-endian: lane k = bits [8k+7:8k].
//
// Ports
//   offset     in   3   byte offset within the 64-bit word (addr[2:0])
//   size       in   2   access size encoding (size_e)
//   is_signed  in   1   sign-extend load result (ignored for doublewords)
//   old_word   in   64  word read from memory
//   wdata      in   64  right-justified store data
//   load_data  out  64  selected lanes shifted down, extended to 64 bits
//   merge_data out  64  old_word with the addressed lanes replaced by wdata
// ---------------------------------------------------------------------------
module byte_lane_align
   import mem_access_pkg::*;
#(
   parameter int DATA_WIDTH = 64
)(
   input  logic [2:0]            offset,
   input  logic [1:0]            size,
   input  logic                  is_signed,
   input  logic [DATA_WIDTH-1:0] old_word,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] load_data,
   output logic [DATA_WIDTH-1:0] merge_data
);

   logic [5:0]                bit_shift;
   logic [DATA_WIDTH-1:0]     lane_shifted;
   logic [DATA_WIDTH-1:0]     wdata_shifted;
   logic [DATA_WIDTH-1:0]     bit_mask;
   logic [BYTES_PER_WORD-1:0] lane_mask;

   assign bit_shift     = {offset, 3'b000};
   assign lane_shifted  = old_word >> bit_shift;
   assign wdata_shifted = wdata << bit_shift;

   // Accesses are aligned before they get here, so the shifted lane mask
   // never spills past lane 7.
   assign lane_mask = size_lane_mask(size) << offset;

   always_comb begin
      load_data = lane_shifted;
      case (size_e'(size))
         SZ_BYTE:
            load_data = {{(DATA_WIDTH-8){is_signed & lane_shifted[7]}}, lane_shifted[7:0]};
         SZ_HALF:
            load_data = {{(DATA_WIDTH-16){is_signed & lane_shifted[15]}}, lane_shifted[15:0]};
         SZ_WORD:
            load_data = {{(DATA_WIDTH-32){is_signed & lane_shifted[31]}}, lane_shifted[31:0]};
         default:
            load_data = lane_shifted;
      endcase
   end

   always_comb begin
      bit_mask = '0;
      for (int k = 0; k < BYTES_PER_WORD; k++) begin
         bit_mask[LANE_BITS*k +: LANE_BITS] = {LANE_BITS{lane_mask[k]}};
      end
   end

   assign merge_data = (old_word & ~bit_mask) | (wdata_shifted & bit_mask);

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// Load/store sequencer between the MEM stage and a 64-bit-only data memory.
// Accepts one byte-addressed request per handshake, faults misaligned or
// out-of-range requests, extracts/extends load lanes and performs
// sub-doubleword stores as read-modify-write.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | ready for a request; fault check and request capture on accept
// READ  | MEM_READ high; load data or old word for merge sampled at exit
// WRITE | MEM_WRITE high; merged (or full) word committed at exit
// RESP  | RSP_VALID pulse with RSP_RDATA / RSP_FAULT; back to IDLE
//
// Ports
//   CLK, RESET                 clock, async active-high reset
//   REQ_VALID/READY            request handshake (READY = IDLE && !RESET)
//   REQ_WRITE/SIZE/SIGNED      store flag, size_e encoding, load extension
//   REQ_ADDR, REQ_WDATA        byte address, right-justified store data
//   RSP_VALID/RDATA/FAULT      one-cycle completion, load data, reject flag
//   MEM_READ/WRITE             memory enables
//   MEM_ADDR_OUT               word index (REQ_ADDR >> 3)
//   MEM_WRITE_DATA             full word to write
//   MEM_DATA_IN                memory read data (combinational)
// ---------------------------------------------------------------------------
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int MEM_DEPTH  = 16
)(
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  REQ_VALID,
   output logic                  REQ_READY,
   input  logic                  REQ_WRITE,
   input  logic [1:0]            REQ_SIZE,
   input  logic                  REQ_SIGNED,
   input  logic [63:0]           REQ_ADDR,
   input  logic [DATA_WIDTH-1:0] REQ_WDATA,
   output logic                  RSP_VALID,
   output logic [DATA_WIDTH-1:0] RSP_RDATA,
   output logic                  RSP_FAULT,
   output logic                  MEM_READ,
   output logic                  MEM_WRITE,
   output logic [63:0]           MEM_ADDR_OUT,
   output logic [DATA_WIDTH-1:0] MEM_WRITE_DATA,
   input  logic [DATA_WIDTH-1:0] MEM_DATA_IN
);

   state_e                state;
   logic [2:0]            req_offset_r;
   logic [1:0]            req_size_r;
   logic                  req_signed_r;
   logic                  req_write_r;
   logic [DATA_WIDTH-1:0] req_wdata_r;

   logic                  misaligned;
   logic                  out_of_range;
   logic                  req_fault;
   logic                  req_full_store;
   logic [DATA_WIDTH-1:0] load_data;
   logic [DATA_WIDTH-1:0] merge_data;

   assign misaligned     = (REQ_ADDR[2:0] & align_mask(REQ_SIZE)) != 3'b000;
   // Full 61-bit compare so huge addresses cannot alias into the array.
   assign out_of_range   = REQ_ADDR[63:3] >= 61'(MEM_DEPTH);
   assign req_fault      = misaligned || out_of_range;
   assign req_full_store = REQ_WRITE && (REQ_SIZE == SZ_DWORD);

   assign REQ_READY = (state == IDLE) && !RESET;

   // Fed straight from MEM_DATA_IN: it is only sampled at the READ exit
   // edge, where the memory is driving the addressed word.
   byte_lane_align #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_align (
      .offset     (req_offset_r),
      .size       (req_size_r),
      .is_signed  (req_signed_r),
      .old_word   (MEM_DATA_IN),
      .wdata      (req_wdata_r),
      .load_data  (load_data),
      .merge_data (merge_data)
   );

   // MEM_WRITE_DATA doubles as the merge register: it holds the old word
   // with the new lanes already spliced in for the whole WRITE state.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state          <= IDLE;
         req_offset_r   <= '0;
         req_size_r     <= '0;
         req_signed_r   <= 1'b0;
         req_write_r    <= 1'b0;
         req_wdata_r    <= '0;
         RSP_VALID      <= 1'b0;
         RSP_FAULT      <= 1'b0;
         RSP_RDATA      <= '0;
         MEM_READ       <= 1'b0;
         MEM_WRITE      <= 1'b0;
         MEM_ADDR_OUT   <= '0;
         MEM_WRITE_DATA <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (REQ_VALID && REQ_READY) begin
                  req_offset_r <= REQ_ADDR[2:0];
                  req_size_r   <= REQ_SIZE;
                  req_signed_r <= REQ_SIGNED;
                  req_write_r  <= REQ_WRITE;
                  req_wdata_r  <= REQ_WDATA;
                  MEM_ADDR_OUT <= {3'b000, REQ_ADDR[63:3]};
                  if (req_fault) begin
                     state     <= RESP;
                     RSP_VALID <= 1'b1;
                     RSP_FAULT <= 1'b1;
                     RSP_RDATA <= '0;
                  end else if (req_full_store) begin
                     state          <= WRITE;
                     MEM_WRITE      <= 1'b1;
                     MEM_WRITE_DATA <= REQ_WDATA;
                  end else begin
                     state    <= READ;
                     MEM_READ <= 1'b1;
                  end
               end
            end

            READ: begin
               MEM_READ <= 1'b0;
               if (req_write_r) begin
                  state          <= WRITE;
                  MEM_WRITE      <= 1'b1;
                  MEM_WRITE_DATA <= merge_data;
               end else begin
                  state     <= RESP;
                  RSP_VALID <= 1'b1;
                  RSP_FAULT <= 1'b0;
                  RSP_RDATA <= load_data;
               end
            end

            WRITE: begin
               state     <= RESP;
               MEM_WRITE <= 1'b0;
               RSP_VALID <= 1'b1;
               RSP_FAULT <= 1'b0;
               RSP_RDATA <= '0;
            end

            RESP: begin
               state     <= IDLE;
               RSP_VALID <= 1'b0;
               RSP_FAULT <= 1'b0;
            end

            default: begin
               state     <= IDLE;
               RSP_VALID <= 1'b0;
               RSP_FAULT <= 1'b0;
               MEM_READ  <= 1'b0;
               MEM_WRITE <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

   localparam int DEPTH = 16;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        REQ_VALID;
   logic        REQ_READY;
   logic        REQ_WRITE;
   logic [1:0]  REQ_SIZE;
   logic        REQ_SIGNED;
   logic [63:0] REQ_ADDR;
   logic [63:0] REQ_WDATA;
   logic        RSP_VALID;
   logic [63:0] RSP_RDATA;
   logic        RSP_FAULT;
   logic        MEM_READ;
   logic        MEM_WRITE;
   logic [63:0] MEM_ADDR_OUT;
   logic [63:0] MEM_WRITE_DATA;
   logic [63:0] MEM_DATA_IN;

   logic [63:0] dmem    [DEPTH];
   logic [63:0] ref_mem [DEPTH];
   logic        pre_we = 1'b0;
   logic [3:0]  pre_idx = '0;
   logic [63:0] pre_data = '0;

   int errors = 0;
   int checks = 0;

   int          obs_rsp_cyc, obs_rd_cyc, obs_wr_cyc, obs_rd_n, obs_wr_n;
   logic        obs_fault, obs_ready_early;
   logic [63:0] obs_rdata, obs_rd_addr, obs_wr_addr, obs_wr_data;

   always #5 CLK = ~CLK;

   mem_access_unit #(.DATA_WIDTH(64), .MEM_DEPTH(DEPTH)) dut (
      .CLK(CLK), .RESET(RESET),
      .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE),
      .REQ_SIZE(REQ_SIZE), .REQ_SIGNED(REQ_SIGNED), .REQ_ADDR(REQ_ADDR),
      .REQ_WDATA(REQ_WDATA), .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA),
      .RSP_FAULT(RSP_FAULT), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
      .MEM_ADDR_OUT(MEM_ADDR_OUT), .MEM_WRITE_DATA(MEM_WRITE_DATA),
      .MEM_DATA_IN(MEM_DATA_IN)
   );

   // DATA_MEM stand-in
   always @(posedge CLK) begin
      if (pre_we) dmem[pre_idx] <= pre_data;
      else if (MEM_WRITE) dmem[MEM_ADDR_OUT[3:0]] <= MEM_WRITE_DATA;
   end
   assign MEM_DATA_IN = MEM_READ ? dmem[MEM_ADDR_OUT[3:0]] : 64'h0;

   // ---------------- reference model (byte-level) ----------------
   function automatic logic ref_fault(input logic [63:0] a, input logic [1:0] sz);
      int nb = 1 << sz;
      return ((a % 64'(nb)) != 0) || ((a / 8) >= 64'(DEPTH));
   endfunction

   function automatic logic [63:0] ref_load(input logic [63:0] a, input logic [1:0] sz, input logic sg);
      int nb = 1 << sz;
      logic [63:0] v = '0;
      for (int i = 0; i < nb; i++) begin
         logic [63:0] ba = a + 64'(i);
         int idx = int'(ba >> 3);
         int lane = int'(ba % 8);
         logic [7:0] b = ref_mem[idx][8*lane +: 8];
         v = v | (64'(b) << (8*i));
      end
      if (sg && nb < 8 && v[8*nb-1]) v = v | (~64'h0 << (8*nb));
      return v;
   endfunction

   task automatic ref_store(input logic [63:0] a, input logic [1:0] sz, input logic [63:0] wd);
      int nb = 1 << sz;
      for (int i = 0; i < nb; i++) begin
         logic [63:0] ba = a + 64'(i);
         int idx = int'(ba >> 3);
         int lane = int'(ba % 8);
         ref_mem[idx][8*lane +: 8] = wd[8*i +: 8];
      end
   endtask

   // Drive one request and record what the DUT does cycle by cycle.
   task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [63:0] a, input logic [63:0] wd);
      @(negedge CLK);
      REQ_VALID = 1'b1; REQ_WRITE = w; REQ_SIZE = sz; REQ_SIGNED = sg;
      REQ_ADDR = a; REQ_WDATA = wd;
      @(posedge CLK);
      #1 REQ_VALID = 1'b0;
      obs_rsp_cyc = -1; obs_rd_cyc = -1; obs_wr_cyc = -1; obs_rd_n = 0; obs_wr_n = 0;
      obs_fault = 1'b0; obs_rdata = '0; obs_ready_early = 1'b0;
      obs_rd_addr = '0; obs_wr_addr = '0; obs_wr_data = '0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge CLK);
         if (REQ_READY) obs_ready_early = 1'b1;
         if (MEM_READ) begin
            obs_rd_n++;
            if (obs_rd_cyc < 0) begin obs_rd_cyc = c; obs_rd_addr = MEM_ADDR_OUT; end
         end
         if (MEM_WRITE) begin
            obs_wr_n++;
            if (obs_wr_cyc < 0) begin
               obs_wr_cyc = c; obs_wr_addr = MEM_ADDR_OUT; obs_wr_data = MEM_WRITE_DATA;
            end
         end
         if (RSP_VALID) begin
            obs_rsp_cyc = c; obs_fault = RSP_FAULT; obs_rdata = RSP_RDATA;
            break;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      RESET = 1'b1; REQ_VALID = 1'b0; REQ_WRITE = 1'b0; REQ_SIZE = '0;
      REQ_SIGNED = 1'b0; REQ_ADDR = '0; REQ_WDATA = '0;
      repeat (2) @(posedge CLK);
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge CLK);
         pre_we = 1'b1; pre_idx = 4'(i);
         pre_data = (i == 0) ? 64'hAAAA : (i == 1) ? 64'hBBBB : {$urandom, $urandom};
         ref_mem[i] = pre_data;
      end
      @(negedge CLK);
      pre_we = 1'b0;
      checks++;
      if ({REQ_READY, RSP_VALID, RSP_FAULT, MEM_READ, MEM_WRITE} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl got %b expected 00000",
                  {REQ_READY, RSP_VALID, RSP_FAULT, MEM_READ, MEM_WRITE});
      end
      checks++;
      if ({RSP_RDATA, MEM_ADDR_OUT, MEM_WRITE_DATA} !== 192'h0) begin
         errors++;
         $display("FAIL reset_data got %h %h %h expected 0", RSP_RDATA, MEM_ADDR_OUT, MEM_WRITE_DATA);
      end
      RESET = 1'b0;
      #1;
      checks++;
      if (REQ_READY !== 1'b1) begin
         errors++; $display("FAIL reset_release_ready got %b expected 1", REQ_READY);
      end
   endtask

   task automatic test_directed();
      run_req(1'b0, 2'b11, 1'b0, 64'h0, 64'h0);
      checks++;
      if (obs_rsp_cyc !== 2 || obs_rd_cyc !== 1) begin
         errors++; $display("FAIL ld_dword_timing got rsp=%0d rd=%0d expected rsp=2 rd=1", obs_rsp_cyc, obs_rd_cyc);
      end
      checks++;
      if (obs_rdata !== 64'h000000000000AAAA || obs_fault !== 1'b0) begin
         errors++; $display("FAIL ld_dword_data got %h f=%b expected 000000000000aaaa f=0", obs_rdata, obs_fault);
      end

      ref_store(64'h9, 2'b00, 64'hFF);
      run_req(1'b1, 2'b00, 1'b0, 64'h9, 64'hFF);
      checks++;
      if (obs_wr_cyc !== 2 || obs_wr_addr !== 64'h1 || obs_rsp_cyc !== 3) begin
         errors++; $display("FAIL st_byte_timing got wr=%0d addr=%h rsp=%0d expected wr=2 addr=1 rsp=3",
                            obs_wr_cyc, obs_wr_addr, obs_rsp_cyc);
      end
      checks++;
      if (obs_wr_data !== 64'h000000000000FFBB) begin
         errors++; $display("FAIL st_byte_merge got %h expected 000000000000ffbb", obs_wr_data);
      end

      run_req(1'b0, 2'b00, 1'b1, 64'h9, 64'h0);
      checks++;
      if (obs_rdata !== 64'hFFFFFFFFFFFFFFFF) begin
         errors++; $display("FAIL ld_byte_signed got %h expected ffffffffffffffff", obs_rdata);
      end
      run_req(1'b0, 2'b00, 1'b0, 64'h9, 64'h0);
      checks++;
      if (obs_rdata !== 64'h00000000000000FF) begin
         errors++; $display("FAIL ld_byte_unsigned got %h expected 00000000000000ff", obs_rdata);
      end
   endtask

   task automatic test_fault();
      run_req(1'b0, 2'b01, 1'b0, 64'h3, 64'h0);
      checks++;
      if (obs_rsp_cyc !== 1 || obs_fault !== 1'b1 || obs_rdata !== 64'h0) begin
         errors++; $display("FAIL misalign_half got rsp=%0d f=%b d=%h expected rsp=1 f=1 d=0",
                            obs_rsp_cyc, obs_fault, obs_rdata);
      end
      checks++;
      if (obs_rd_n !== 0 || obs_wr_n !== 0) begin
         errors++; $display("FAIL misalign_mem got rd=%0d wr=%0d expected 0 0", obs_rd_n, obs_wr_n);
      end
      run_req(1'b0, 2'b11, 1'b0, 64'h80, 64'h0);
      checks++;
      if (obs_rsp_cyc !== 1 || obs_fault !== 1'b1 || obs_rd_n !== 0) begin
         errors++; $display("FAIL range_0x80 got rsp=%0d f=%b rd=%0d expected rsp=1 f=1 rd=0",
                            obs_rsp_cyc, obs_fault, obs_rd_n);
      end
      run_req(1'b0, 2'b11, 1'b0, 64'h78, 64'h0);
      checks++;
      if (obs_rsp_cyc !== 2 || obs_fault !== 1'b0 || obs_rdata !== ref_mem[15]) begin
         errors++; $display("FAIL range_0x78 got rsp=%0d f=%b d=%h expected rsp=2 f=0 d=%h",
                            obs_rsp_cyc, obs_fault, obs_rdata, ref_mem[15]);
      end
      run_req(1'b1, 2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h1234);
      checks++;
      if (obs_rsp_cyc !== 1 || obs_fault !== 1'b1 || obs_wr_n !== 0) begin
         errors++; $display("FAIL range_high_store got rsp=%0d f=%b wr=%0d expected rsp=1 f=1 wr=0",
                            obs_rsp_cyc, obs_fault, obs_wr_n);
      end
   endtask

   task automatic test_reset_mid_op();
      logic saw = 1'b0;
      @(negedge CLK);
      REQ_VALID = 1'b1; REQ_WRITE = 1'b1; REQ_SIZE = 2'b10; REQ_SIGNED = 1'b0;
      REQ_ADDR = 64'h4; REQ_WDATA = {$urandom, $urandom};
      @(posedge CLK);
      #1 REQ_VALID = 1'b0;
      @(negedge CLK);
      checks++;
      if (MEM_READ !== 1'b1) begin
         errors++; $display("FAIL rmw_read_phase got %b expected 1", MEM_READ);
      end
      RESET = 1'b1;
      #1;
      checks++;
      if (MEM_READ !== 1'b0 || REQ_READY !== 1'b0) begin
         errors++; $display("FAIL async_reset got rd=%b rdy=%b expected 0 0", MEM_READ, REQ_READY);
      end
      repeat (3) begin
         @(negedge CLK);
         if (MEM_WRITE || RSP_VALID) saw = 1'b1;
      end
      checks++;
      if (saw !== 1'b0) begin
         errors++; $display("FAIL reset_no_write got %b expected 0", saw);
      end
      RESET = 1'b0;
      #1;
      checks++;
      if (REQ_READY !== 1'b1) begin
         errors++; $display("FAIL reset_mid_ready got %b expected 1", REQ_READY);
      end
      checks++;
      if (dmem[0] !== ref_mem[0]) begin
         errors++; $display("FAIL reset_word0 got %h expected %h", dmem[0], ref_mem[0]);
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] exp_a, exp_b;
      int rsp_cyc[$];
      logic [63:0] rsp_dat[$];
      int ready_cyc = -1;
      int ia = $urandom_range(0, DEPTH-1);
      int ib = $urandom_range(0, DEPTH-1);
      exp_a = ref_mem[ia]; exp_b = ref_mem[ib];
      @(negedge CLK);
      REQ_VALID = 1'b1; REQ_WRITE = 1'b0; REQ_SIZE = 2'b11; REQ_SIGNED = 1'b0;
      REQ_ADDR = 64'(ia) << 3;
      @(posedge CLK);
      #1 REQ_ADDR = 64'(ib) << 3;
      for (int c = 1; c <= 5; c++) begin
         @(negedge CLK);
         if (REQ_READY && ready_cyc < 0) ready_cyc = c;
         if (RSP_VALID) begin rsp_cyc.push_back(c); rsp_dat.push_back(RSP_RDATA); end
      end
      REQ_VALID = 1'b0;
      @(negedge CLK);
      checks++;
      if (ready_cyc !== 3) begin
         errors++; $display("FAIL b2b_accept_cycle got %0d expected 3", ready_cyc);
      end
      checks++;
      if (rsp_cyc.size() != 2 || rsp_cyc[0] != 2 || rsp_cyc[1] != 5) begin
         errors++; $display("FAIL b2b_rsp_cycles got n=%0d expected cycles 2,5", rsp_cyc.size());
      end else begin
         checks++;
         if (rsp_dat[0] !== exp_a || rsp_dat[1] !== exp_b) begin
            errors++; $display("FAIL b2b_data got %h %h expected %h %h", rsp_dat[0], rsp_dat[1], exp_a, exp_b);
         end
      end
      checks++;
      if (RSP_VALID !== 1'b0 || REQ_READY !== 1'b1) begin
         errors++; $display("FAIL b2b_no_third got v=%b rdy=%b expected 0 1", RSP_VALID, REQ_READY);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 80; n++) begin
         logic        w  = 1'($urandom_range(0, 1));
         logic [1:0]  sz = 2'($urandom_range(0, 3));
         logic        sg = 1'($urandom_range(0, 1));
         int          idx = $urandom_range(0, 19);
         logic [2:0]  off = 3'($urandom_range(0, 7));
         logic [63:0] a, wd, exp_rdata;
         logic        exp_fault;
         int          exp_rsp, exp_rd_n, exp_wr_n, exp_wr_cyc;
         if ($urandom_range(0, 3) != 0) off = off & ~3'((1 << sz) - 1);
         a = (64'(idx) << 3) | 64'(off);
         if ($urandom_range(0, 15) == 0) a[63:40] = 24'($urandom);
         wd = {$urandom, $urandom};
         exp_fault = ref_fault(a, sz);
         exp_rdata = (!w && !exp_fault) ? ref_load(a, sz, sg) : 64'h0;
         if (w && !exp_fault) ref_store(a, sz, wd);
         exp_rsp    = exp_fault ? 1 : (w && sz != 2'b11) ? 3 : 2;
         exp_rd_n   = (exp_fault || (w && sz == 2'b11)) ? 0 : 1;
         exp_wr_n   = (!exp_fault && w) ? 1 : 0;
         exp_wr_cyc = (sz == 2'b11) ? 1 : 2;
         run_req(w, sz, sg, a, wd);
         checks++;
         if (obs_rsp_cyc !== exp_rsp || obs_fault !== exp_fault) begin
            errors++; $display("FAIL rnd%0d_rsp a=%h w=%b sz=%0d got cyc=%0d f=%b expected cyc=%0d f=%b",
                               n, a, w, sz, obs_rsp_cyc, obs_fault, exp_rsp, exp_fault);
         end
         checks++;
         if (obs_rdata !== exp_rdata) begin
            errors++; $display("FAIL rnd%0d_rdata a=%h sz=%0d sg=%b got %h expected %h",
                               n, a, sz, sg, obs_rdata, exp_rdata);
         end
         checks++;
         if (obs_rd_n !== exp_rd_n || obs_wr_n !== exp_wr_n || obs_ready_early !== 1'b0) begin
            errors++; $display("FAIL rnd%0d_enables got rd=%0d wr=%0d rdy=%b expected rd=%0d wr=%0d rdy=0",
                               n, obs_rd_n, obs_wr_n, obs_ready_early, exp_rd_n, exp_wr_n);
         end
         if (exp_rd_n == 1) begin
            checks++;
            if (obs_rd_cyc !== 1 || obs_rd_addr !== a >> 3) begin
               errors++; $display("FAIL rnd%0d_read got cyc=%0d addr=%h expected cyc=1 addr=%h",
                                  n, obs_rd_cyc, obs_rd_addr, a >> 3);
            end
         end
         if (exp_wr_n == 1) begin
            checks++;
            if (obs_wr_cyc !== exp_wr_cyc || obs_wr_addr !== 64'(idx) || obs_wr_data !== ref_mem[idx]) begin
               errors++; $display("FAIL rnd%0d_write got cyc=%0d addr=%h d=%h expected cyc=%0d addr=%h d=%h",
                                  n, obs_wr_cyc, obs_wr_addr, obs_wr_data, exp_wr_cyc, 64'(idx), ref_mem[idx]);
            end
         end
      end
      @(negedge CLK);
      for (int i = 0; i < DEPTH; i++) begin
         checks++;
         if (dmem[i] !== ref_mem[i]) begin
            errors++; $display("FAIL mem_word%0d got %h expected %h", i, dmem[i], ref_mem[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_fault();
      test_reset_mid_op();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout after %0d checks", checks);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store sequencer that sits between the datapath MEM stage and the `DATA_MEM` data memory, acting as the initiator side of its `MEM_READ`/`MEM_WRITE`/address/data interface. It accepts one byte-addressed load or store per handshake. It converts the byte address to a 64-bit word index and checks alignment and range. Loads get lane extraction with sign or zero extension. Sub-doubleword stores are performed as a read-modify-write sequence against the 64-bit-only memory.

## Interface
- `DATA_WIDTH`, 64, memory word width in bits; fixed at 64, byte-lane logic assumes 8 lanes.
- `MEM_DEPTH`, 16, number of 64-bit words in `DATA_MEM`; word index must be < `MEM_DEPTH`.
- `CLK`  in  1  system clock, all state updates on rising edge.
- `RESET`  in  1  asynchronous, active-high reset.
- `REQ_VALID`  in  1  request present.
- `REQ_READY`  out  1  unit can accept; equals (state==IDLE) && !RESET.
- `REQ_WRITE`  in  1  1 = store, 0 = load.
- `REQ_SIZE`  in  2  00 byte, 01 half, 10 word, 11 doubleword.
- `REQ_SIGNED`  in  1  load result sign-extended when 1, zero-extended when 0; ignored for stores and doublewords.
- `REQ_ADDR`  in  64  byte address.
- `REQ_WDATA`  in  64  store data, right-justified (low `8<<REQ_SIZE` bits used).
- `RSP_VALID`  out  1  one-cycle completion pulse.
- `RSP_RDATA`  out  64  load result; 0 for stores and faults.
- `RSP_FAULT`  out  1  request rejected (misaligned or out of range); qualified by `RSP_VALID`.
- `MEM_READ`  out  1  to `DATA_MEM` read enable.
- `MEM_WRITE`  out  1  to `DATA_MEM` write enable.
- `MEM_ADDR_OUT`  out  64  word index (`REQ_ADDR >> 3`), zero-extended.
- `MEM_WRITE_DATA`  out  64  full 64-bit word to write.
- `MEM_DATA_IN`  in  64  `DATA_MEM` read data, combinational from `MEM_ADDR_OUT` while `MEM_READ`=1.

## Operation
- FSM states: IDLE, READ, WRITE, RESP. Moore outputs: `MEM_READ`=1 only in READ, `MEM_WRITE`=1 only in WRITE, `RSP_VALID`=1 only in RESP.
- IDLE: on `REQ_VALID && REQ_READY`, latch ADDR/SIZE/SIGNED/WRITE/WDATA into request registers.
- Fault check at accept:
  - misaligned when `REQ_ADDR & ((1<<REQ_SIZE)-1)` is nonzero;
  - out of range when `REQ_ADDR[63:3] >= MEM_DEPTH`;
  - on fault, go to RESP with FAULT=1 and never assert MEM_READ/MEM_WRITE.
- Load: IDLE→READ→RESP. At the READ→RESP edge, capture `(MEM_DATA_IN >> 8*addr[2:0])`, masked to size and extended per SIGNED, into `RSP_RDATA`.
- Store doubleword: IDLE→WRITE→RESP, with `MEM_WRITE_DATA`=WDATA.
- Store byte/half/word: IDLE→READ→WRITE→RESP.
  - READ captures the old word into a merge register.
  - WRITE drives the old word with lanes `[addr[2:0] .. addr[2:0]+bytes-1]` replaced by WDATA's low bytes; all other lanes are unchanged.
- RESP always returns to IDLE. No response backpressure.
- Little-endian: lane k = bits [8k+7:8k].

## Timing
- Accept edge = cycle 0.
- Load: MEM_READ in cycle 1, RSP_VALID in cycle 2.
- Doubleword store: MEM_WRITE in cycle 1 (memory commits on its closing edge), RSP_VALID in cycle 2.
- Sub-word store: READ in cycle 1, WRITE in cycle 2, RSP_VALID in cycle 3.
- Fault: RSP_VALID+RSP_FAULT in cycle 1.
- REQ_READY is low from the cycle after accept until IDLE is re-entered. Minimum spacing between accepts: 2 (fault), 3 (load/doubleword store), 4 (sub-word store).
- `MEM_ADDR_OUT` and `MEM_WRITE_DATA` are held stable from the request registers for the whole READ/WRITE state.
- Reset values: state IDLE; RSP_VALID, RSP_FAULT, MEM_READ, MEM_WRITE = 0; RSP_RDATA, MEM_ADDR_OUT, MEM_WRITE_DATA and all request/merge registers = 0; REQ_READY = 0 while RESET is high and 1 in the first cycle after release.
- Reset mid-operation: immediate return to IDLE with outputs deasserted. If RESET asserts before the WRITE edge, no write occurs and no response is issued.

## Structure
- Package `mem_access_pkg`: size encodings (SZ_BYTE/HALF/WORD/DWORD), FSM state enum, `BYTES_PER_WORD`=8.
- Sub-module `byte_lane_align`: combinational load extract/extend plus store merge (inputs: offset, size, signed, old word, wdata). Shared by load and read-modify-write paths.

## Test plan
- After reset, load doubleword at addr 0x0 (word0=0xAAAA) -> RSP_VALID cycle 2, RSP_RDATA=0x000000000000AAAA, FAULT=0.
- Store byte 0xFF to addr 0x9 (word1=0xBBBB) -> MEM_WRITE in cycle 2 with MEM_ADDR_OUT=1, MEM_WRITE_DATA=0x000000000000FFBB. Then signed byte load at 0x9 -> 0xFFFFFFFFFFFFFFFF; unsigned -> 0x00000000000000FF.
- Half load at addr 0x3 -> RSP_VALID+RSP_FAULT in cycle 1, RSP_RDATA=0, MEM_READ/MEM_WRITE never high.
- Doubleword load at addr 0x80 (index 16, MEM_DEPTH=16) -> fault; 0x78 -> accepted, no fault.
- Word store to 0x4, RESET pulsed during READ -> MEM_WRITE never asserted, word0 unchanged, REQ_READY=1 first cycle after release.
- REQ_VALID held high with two back-to-back doubleword loads -> second accepted at cycle 3, responses in cycles 2 and 5.
